vga_sync: RTL and testbench

Raster timing generator for the VGA display path: derives a pixel-rate enable from the system clock, and scans horizontal and vertical position counters. It drives the sync pulses, the visible-area flag and the current pixel coordinates. Its `opixel_x` and `opixel_y` outputs feed the `ipixel_x` and `ipixel_y` inputs of every draw_* object renderer. Its `oframe_tick` output paces per-frame game-state updates.

---
 rtl/vga_sync_pkg.sv | 29 ++
 rtl/vga_sync_mod_counter.sv | 38 +++
 rtl/vga_sync.sv | 98 +++++++++
 tb/tb_vga_sync.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_pkg.sv
// Shared VGA raster constants and helpers, imported by the timing generator
// and by anything that needs the default screen geometry.
package vga_sync_pkg;

  localparam int COORD_W = 10;
  localparam int DIV_W   = 4;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 2;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // True while pos lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                     input int lo, input int len);
    int p;
    p = int'(pos);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_mod_counter.sv
// Modulo-N counter with enable, synchronous reset, look-ahead next value and
// a one-cycle wrap pulse on the enabled step from N-1 back to 0.
module vga_sync_mod_counter #(
  parameter int MODULUS = 2,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic at_last;

  assign at_last = (count == LAST);
  assign wrap    = en && at_last;

  // Next value is exposed so registers downstream can stay aligned with count.
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = at_last ? '0 : count + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-rate enable, h/v position counters,
// registered active-low syncs, visible-area flag and end-of-frame pulse.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic               iclk,
  input  logic               ireset,
  output logic               opixel_tick,
  output logic [COORD_W-1:0] opixel_x,
  output logic [COORD_W-1:0] opixel_y,
  output logic               ohsync,
  output logic               ovsync,
  output logic               ovideo_on,
  output logic               oframe_tick
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   div_next;
  logic               div_wrap;
  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] h_next;
  logic               h_wrap;
  logic [COORD_W-1:0] v;
  logic [COORD_W-1:0] v_next;
  logic               v_wrap;
  logic               pixel_tick;
  logic               hsync_q;
  logic               vsync_q;
  logic               unused_div;

  vga_sync_mod_counter #(.MODULUS(CLK_DIV), .WIDTH(DIV_W)) u_div (
    .clock      (iclk),
    .reset      (ireset),
    .en         (1'b1),
    .count      (div),
    .count_next (div_next),
    .wrap       (div_wrap)
  );

  // Gating with reset keeps a stray tick from escaping on the reset cycle.
  assign pixel_tick = (div == DIV_LAST) && !ireset;
  assign unused_div = ^{div_next, div_wrap};

  vga_sync_mod_counter #(.MODULUS(H_TOTAL), .WIDTH(COORD_W)) u_h (
    .clock      (iclk),
    .reset      (ireset),
    .en         (pixel_tick),
    .count      (h),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  vga_sync_mod_counter #(.MODULUS(V_TOTAL), .WIDTH(COORD_W)) u_v (
    .clock      (iclk),
    .reset      (ireset),
    .en         (h_wrap),
    .count      (v),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Syncs load from the counters' next values so they change on the same edge as x/y.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= ~in_window(h_next, H_SYNC_START, H_SYNC);
      vsync_q <= ~in_window(v_next, V_SYNC_START, V_SYNC);
    end
  end

  assign opixel_tick = pixel_tick;
  assign opixel_x    = h;
  assign opixel_y    = v;
  assign ohsync      = hsync_q;
  assign ovsync      = vsync_q;
  assign ovideo_on   = (h < COORD_W'(H_DISPLAY)) && (v < COORD_W'(V_DISPLAY));
  assign oframe_tick = v_wrap;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: scoreboarded raster on a reduced timing, plus directed
// checks on a default-timing build and a CLK_DIV=1 build.
module tb_vga_sync;

  localparam int S_HT = 15;
  localparam int S_VT = 10;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       frame;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ireset  = 1'b1;
  logic rst_def = 1'b1;

  logic       s_tick, s_hs, s_vs, s_von, s_frame;
  logic [9:0] s_x, s_y;
  logic       d1_tick, d1_hs, d1_vs, d1_von, d1_frame;
  logic [9:0] d1_x, d1_y;
  logic       d_tick, d_hs, d_vs, d_von, d_frame;
  logic [9:0] d_x, d_y;

  exp_t sb_q[$];
  exp_t cur;
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;
  bit   d1_done = 1'b0;
  bit   def_done = 1'b0;

  // Reduced raster: 15 ticks per line, 10 lines, hsync x in [10,12], vsync y in [7,8].
  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(3)
  ) dut (
    .iclk(clk), .ireset(ireset), .opixel_tick(s_tick), .opixel_x(s_x), .opixel_y(s_y),
    .ohsync(s_hs), .ovsync(s_vs), .ovideo_on(s_von), .oframe_tick(s_frame)
  );

  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)
  ) dut_d1 (
    .iclk(clk), .ireset(ireset), .opixel_tick(d1_tick), .opixel_x(d1_x), .opixel_y(d1_y),
    .ohsync(d1_hs), .ovsync(d1_vs), .ovideo_on(d1_von), .oframe_tick(d1_frame)
  );

  vga_sync dut_def (
    .iclk(clk), .ireset(rst_def), .opixel_tick(d_tick), .opixel_x(d_x), .opixel_y(d_y),
    .ohsync(d_hs), .ovsync(d_vs), .ovideo_on(d_von), .oframe_tick(d_frame)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: wait budget expired, got no event, expected one", name);
  endtask

  function automatic exp_t expectAt(input int p);
    exp_t e;
    int   x;
    int   y;
    x       = p % S_HT;
    y       = (p / S_HT) % S_VT;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.hs    = !(x >= 10 && x <= 12);
    e.vs    = !(y >= 7 && y <= 8);
    e.von   = (x < 8) && (y < 6);
    e.frame = (x == 14) && (y == 9);
    return e;
  endfunction

  task automatic applyStimulus(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(expectAt(first + i));
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout(name);
    mon_en = 1'b0;
    sb_q.delete();
  endtask

  // Monitor: every tick of the reduced DUT consumes one expected pixel.
  always @(negedge clk) begin
    if (mon_en && s_tick) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL sb_extra_tick: got tick at x=%0d y=%0d, expected none", s_x, s_y);
      end else begin
        cur = sb_q.pop_front();
        checkOutput("sb_x", int'(s_x), int'(cur.x));
        checkOutput("sb_y", int'(s_y), int'(cur.y));
        checkOutput("sb_hsync", int'(s_hs), int'(cur.hs));
        checkOutput("sb_vsync", int'(s_vs), int'(cur.vs));
        checkOutput("sb_video_on", int'(s_von), int'(cur.von));
        checkOutput("sb_frame_tick", int'(s_frame), int'(cur.frame));
      end
    end
  end

  initial begin : main_block
    bit found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_x", int'(s_x), 0);
    checkOutput("rst_y", int'(s_y), 0);
    checkOutput("rst_hsync", int'(s_hs), 1);
    checkOutput("rst_vsync", int'(s_vs), 1);
    checkOutput("rst_video_on", int'(s_von), 1);
    checkOutput("rst_tick", int'(s_tick), 0);
    checkOutput("rst_frame_tick", int'(s_frame), 0);

    @(posedge clk);
    #1;
    ireset = 1'b0;
    applyStimulus(0, 170);
    mon_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checkOutput("first_tick_cycle", int'(s_tick), int'(c % 3 == 2));
      checkOutput("pixel_x_hold", int'(s_x), c / 3);
    end
    waitDrain("frame_drain", 600);

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (s_tick && s_x == 10'd11 && s_y == 10'd8) found = 1'b1;
    end
    if (!found) begin
      reportTimeout("mid_frame_point");
    end else begin
      checkOutput("pre_rst_hsync", int'(s_hs), 0);
      checkOutput("pre_rst_vsync", int'(s_vs), 0);
      ireset = 1'b1;
      #1;
      checkOutput("tick_gated_by_reset", int'(s_tick), 0);
      @(negedge clk);
      checkOutput("midrst_x", int'(s_x), 0);
      checkOutput("midrst_y", int'(s_y), 0);
      checkOutput("midrst_hsync", int'(s_hs), 1);
      checkOutput("midrst_vsync", int'(s_vs), 1);
      checkOutput("midrst_video_on", int'(s_von), 1);
      checkOutput("midrst_frame_tick", int'(s_frame), 0);
    end

    @(posedge clk);
    #1;
    ireset = 1'b0;
    applyStimulus(0, 20);
    mon_en = 1'b1;
    waitDrain("restart_drain", 100);

    for (int i = 0; i < 3000 && !(d1_done && def_done); i++) @(posedge clk);
    if (!(d1_done && def_done)) reportTimeout("side_checks_done");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin : d1_block
    int first_ft;
    int second_ft;
    @(negedge clk);
    checkOutput("d1_rst_x", int'(d1_x), 0);
    checkOutput("d1_rst_y", int'(d1_y), 0);
    checkOutput("d1_rst_hsync", int'(d1_hs), 1);
    checkOutput("d1_rst_vsync", int'(d1_vs), 1);
    checkOutput("d1_rst_video_on", int'(d1_von), 1);
    checkOutput("d1_rst_tick", int'(d1_tick), 0);
    checkOutput("d1_rst_frame_tick", int'(d1_frame), 0);
    @(negedge ireset);
    first_ft  = -1;
    second_ft = -1;
    for (int c = 0; c < 400 && second_ft < 0; c++) begin
      @(negedge clk);
      if (c < 8) checkOutput("d1_tick_every_cycle", int'(d1_tick), 1);
      if (d1_frame) begin
        if (first_ft < 0) first_ft = c;
        else second_ft = c;
      end
    end
    if (second_ft < 0) begin
      reportTimeout("d1_frame_period");
    end else begin
      checkOutput("d1_first_frame_cycle", first_ft, 149);
      checkOutput("d1_frame_period", second_ft - first_ft, 150);
    end
    d1_done = 1'b1;
  end

  initial begin : def_block
    int hs_low;
    int hs_first;
    int von_fall;
    int prev_x;
    bit wrapped;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("def_rst_x", int'(d_x), 0);
    checkOutput("def_rst_y", int'(d_y), 0);
    checkOutput("def_rst_hsync", int'(d_hs), 1);
    checkOutput("def_rst_vsync", int'(d_vs), 1);
    checkOutput("def_rst_video_on", int'(d_von), 1);
    checkOutput("def_rst_tick", int'(d_tick), 0);
    checkOutput("def_rst_frame_tick", int'(d_frame), 0);
    @(posedge clk);
    #1;
    rst_def = 1'b0;
    @(negedge clk);
    checkOutput("def_tick_c0", int'(d_tick), 0);
    @(negedge clk);
    checkOutput("def_tick_c1", int'(d_tick), 1);
    checkOutput("def_x_c1", int'(d_x), 0);
    @(negedge clk);
    checkOutput("def_x_c2", int'(d_x), 1);

    hs_low   = 0;
    hs_first = -1;
    von_fall = -1;
    prev_x   = -1;
    wrapped  = 1'b0;
    for (int i = 0; i < 1700 && !wrapped; i++) begin
      @(negedge clk);
      if (d_tick) begin
        if (prev_x == 799) begin
          checkOutput("def_wrap_x", int'(d_x), 0);
          checkOutput("def_wrap_y", int'(d_y), 1);
          wrapped = 1'b1;
        end else begin
          if (!d_hs) begin
            hs_low++;
            if (hs_first < 0) hs_first = int'(d_x);
          end
          if (!d_von && von_fall < 0) von_fall = int'(d_x);
          prev_x = int'(d_x);
        end
      end
    end
    if (!wrapped) reportTimeout("def_line_wrap");
    checkOutput("def_hsync_low_ticks", hs_low, 96);
    checkOutput("def_hsync_start_x", hs_first, 656);
    checkOutput("def_video_on_fall_x", von_fall, 640);
    def_done = 1'b1;
  end

endmodule
